// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned ALU with 1-cycle add/sub, a shift-add multiplier and a restoring divider.
// Define SEQ_ALU_DIV_EN to build the divider; without it div/mod finish at once with error 2'b11.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic [3:0]         command,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         error
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_MOD = 4'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [1:0]         err_q, err_d;

  logic               accept, start_iter, sub_op;
  logic [WIDTH-1:0]   b_x;
  logic [WIDTH:0]     sum, mul_sum;
  logic [2*WIDTH-1:0] quick_res, mul_acc, iter_acc, final_res;
  logic [1:0]         quick_err;

  assign accept = in_valid && (state_q == IDLE);

  // Single-cycle results; overflow = carry into MSB xor carry out, recovered from the MSB sum bit
  always_comb begin
    sub_op     = (command == CMD_SUB);
    b_x        = sub_op ? ~input_b : input_b;
    sum        = {1'b0, input_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_op};
    quick_res  = '0;
    quick_err  = 2'b00;
    start_iter = (command == CMD_MUL);
    case (command)
      CMD_ADD, CMD_SUB: begin
        quick_res = {{(WIDTH-1){1'b0}}, sum};
        quick_err = {1'b0, sum[WIDTH] ^ sum[WIDTH-1] ^ input_a[WIDTH-1] ^ b_x[WIDTH-1]};
      end
`ifdef SEQ_ALU_DIV_EN
      CMD_DIV, CMD_MOD: begin
        quick_err  = 2'b10;
        start_iter = (input_b != '0);
      end
`else
      CMD_DIV, CMD_MOD: quick_err = 2'b11;
`endif
      default: ;
    endcase
  end

  // Multiplier step: {hi, lo} with the multiplier in lo, shifted right one bit per cycle
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic [3:0]         cmd_q, cmd_d;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_acc;

  assign cmd_d = accept ? command : cmd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_q <= '0;
    else        cmd_q <= cmd_d;
  end

  // Restoring divider step: remainder in hi, dividend shifting out / quotient shifting in at lo
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    if (div_shift[WIDTH] || !div_diff[WIDTH])
      div_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    iter_acc  = (cmd_q == CMD_MUL) ? mul_acc : div_acc;
    final_res = iter_acc;
    if (cmd_q == CMD_DIV)      final_res = {{WIDTH{1'b0}}, iter_acc[WIDTH-1:0]};
    else if (cmd_q == CMD_MOD) final_res = {{WIDTH{1'b0}}, iter_acc[2*WIDTH-1:WIDTH]};
  end
`else
  always_comb begin
    iter_acc  = mul_acc;
    final_res = mul_acc;
  end
`endif

  always_comb begin
    opd_d = opd_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    err_d = err_q;
    if (accept) begin
      cnt_d = '0;
      res_d = quick_res;
      err_d = quick_err;
      if (command == CMD_MUL) begin
        opd_d = input_a;
        acc_d = {{WIDTH{1'b0}}, input_b};
      end else begin
        opd_d = input_b;
        acc_d = {{WIDTH{1'b0}}, input_a};
      end
    end else if (state_q == RUN) begin
      acc_d = iter_acc;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        res_d = final_res;
        err_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opd_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 2'b00;
    end else begin
      opd_q <= opd_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = start_iter ? RUN : DONE;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = res_q;
    error     = err_q;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width (legal range 4..32).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand/command offer.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 input_a  input  WIDTH  operand A, unsigned.
REQ-007 input_b  input  WIDTH  operand B, unsigned.
REQ-008 command  input  4  1=add, 2=sub, 3=mul, 4=div, 5=mod, all others are ground.
REQ-009 out_valid  output  1  result/error valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  2*WIDTH  registered result.
REQ-012 error  output  2  bit1=divide-by-zero, bit0=signed overflow; 2'b11=unsupported.

Function
REQ-013 The block SHALL accept a transaction on a rising edge with in_valid=1 and in_ready=1, and SHALL capture input_a, input_b and command there; input changes SHALL be ignored after that edge.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE. Transitions: IDLE->DONE on accepting add/sub/ground/div-by-zero; IDLE->RUN on accepting mul/div/mod with a legal operand; RUN->DONE after exactly WIDTH iteration cycles; DONE->IDLE on out_ready=1.
REQ-015 Add/sub SHALL compute A+B or A+~B+1.
  - result[WIDTH-1:0] = sum; result[WIDTH] = carry-out; all higher bits 0.
  - error[0] = carry into MSB XOR carry-out; error[1] = 0.
REQ-016 Mul SHALL be an unsigned shift-add, one partial product per cycle, giving the full 2*WIDTH product; error SHALL be 2'b00.
REQ-017 Div/mod SHALL be an unsigned restoring divider, one quotient bit per cycle; result SHALL be the quotient (div) or remainder (mod), zero-extended; error SHALL be 2'b00.
REQ-018 Div/mod with B=0 SHALL NOT iterate; result SHALL be 0 and error 2'b10.
REQ-019 Ground commands SHALL give result 0 and error 2'b00.
REQ-020 Latency from the accepting edge to out_valid high SHALL be 1 cycle for single-cycle operations and WIDTH+1 cycles for mul/div/mod.
REQ-021 In DONE, out_valid, result and error SHALL stay stable until the edge where out_ready=1; that edge returns the FSM to IDLE. The earliest next accept is the following edge.
REQ-022 out_valid and in_ready SHALL never be high together; in_ready SHALL be low in RUN and DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, out_valid=0, result=0, error=2'b00 and clear all datapath registers, including during RUN or DONE. An interrupted operation SHALL produce no output.
REQ-024 in_ready SHALL be 1 on the first rising edge after rst_n deasserts.

Configuration
REQ-025 With macro SEQ_ALU_DIV_EN defined, the divider SHALL be built and commands 4/5 SHALL behave as in REQ-017/018.
REQ-026 Without SEQ_ALU_DIV_EN, no divider logic SHALL be built; commands 4/5 SHALL complete in 1 cycle with result 0 and error 2'b11.

Verification (WIDTH=16, SEQ_ALU_DIV_EN defined, out_ready=1 unless stated)
REQ-027 A=249, B=69:
  - cmd1 -> result 318, error 00, 1 cycle.
  - cmd2 -> result 180 with bit16=1 (carry), error 00.
  - cmd3 -> result 17181, error 00, out_valid 17 cycles after accept.
REQ-028 A=32000, B=8193:
  - cmd1 -> result 40193, error 01.
  - cmd4 -> result 3, error 00.
  - cmd5 -> result 7421, error 00, 17-cycle latency.
REQ-029 A=5, B=0, cmd4 and cmd5 -> result 0, error 10, 1-cycle latency; cmd9 -> result 0, error 00.
REQ-030 cmd3 with A=65535, B=65535 and out_ready held low 5 cycles -> result 4294836225 stable and out_valid held until out_ready=1; in_ready low throughout; accept possible the cycle after release.
REQ-031 Assert rst_n=0 at iteration 8 of a cmd3 operation -> out_valid, result and error read 0 immediately; no stale result after release; the next cmd1 (1+1) returns 2.
REQ-032 Build without SEQ_ALU_DIV_EN, cmd4 with A=10, B=2 -> result 0, error 11, 1-cycle latency.
